// File: rtl/csat_enum_driver.sv
`default_nettype none
// ============================================================================
// csat_enum_driver : drives every N-input assignment in ascending order into a
// circuit-SAT benchmark and streams out the satisfying ones.
// Revision 1.0
// ============================================================================
module csat_enum_driver #(
    parameter int N_INPUTS    = 7,
    parameter int SAT_LATENCY = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                find_all,
    output logic [N_INPUTS-1:0] assignment,
    input  logic                sat_i,
    output logic                sol_valid,
    input  logic                sol_ready,
    output logic [N_INPUTS-1:0] sol_data,
    output logic [N_INPUTS:0]   sol_count,
    output logic                busy,
    output logic                done,
    output logic                found
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_EMIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [N_INPUTS-1:0] C_ASG_LAST   = '1;
    localparam logic [N_INPUTS-1:0] C_ASG_ONE    = N_INPUTS'(1);
    localparam logic [N_INPUTS:0]   C_CNT_ONE    = (N_INPUTS + 1)'(1);
    localparam logic [1:0]          C_DWELL_LAST = 2'(SAT_LATENCY);

    state_t     r_state;
    logic [1:0] r_dwell;
    logic       r_mode;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_dwell    <= 2'd0;
            r_mode     <= 1'b0;
            assignment <= '0;
            sol_valid  <= 1'b0;
            sol_data   <= '0;
            sol_count  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            found      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_state    <= S_RUN;
                        r_dwell    <= 2'd0;
                        r_mode     <= find_all;
                        assignment <= '0;
                        sol_count  <= '0;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        found      <= 1'b0;
                    end
                end
                S_RUN: begin
                    // sat_i only reflects the current candidate in its last dwell cycle
                    if (r_dwell != C_DWELL_LAST) begin
                        r_dwell <= r_dwell + 2'd1;
                    end else if (sat_i) begin
                        sol_data  <= assignment;
                        sol_valid <= 1'b1;
                        sol_count <= sol_count + C_CNT_ONE;
                        r_state   <= S_EMIT;
                    end else if (assignment == C_ASG_LAST) begin
                        r_state <= S_DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        found   <= (sol_count != '0);
                    end else begin
                        assignment <= assignment + C_ASG_ONE;
                        r_dwell    <= 2'd0;
                    end
                end
                S_EMIT: begin
                    if (sol_ready) begin
                        sol_valid <= 1'b0;
                        if (!r_mode || assignment == C_ASG_LAST) begin
                            r_state <= S_DONE;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            found   <= (sol_count != '0);
                        end else begin
                            assignment <= assignment + C_ASG_ONE;
                            r_dwell    <= 2'd0;
                            r_state    <= S_RUN;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
